// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// master = requester side, slave = converter side.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (output start, bin_in, input busy, done, bcd_out);
  modport slave  (input start, bin_in, output busy, done, bcd_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 (double dabble) binary-to-BCD converter, one bit per clock.
// Each 4-bit digit of bcd_out feeds a downstream BCD-to-excess-3 converter.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bif
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic { IDLE, SHIFT } state_t;

  state_t            state, state_n;
  logic [BIN_W-1:0]  sh_q, sh_n;
  logic [BW-1:0]     scr_q, scr_n;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [BW-1:0]     bcd_q, bcd_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh_q   <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
    end else begin
      state  <= state_n;
      sh_q   <= sh_n;
      scr_q  <= scr_n;
      cnt_q  <= cnt_n;
      busy_q <= busy_n;
      done_q <= done_n;
      bcd_q  <= bcd_n;
    end
  end

  // Digits >= 5 get +3 before the shift so they carry correctly into the next digit.
  always_comb begin
    adj = scr_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scr_q[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh_q;
    scr_n   = scr_q;
    cnt_n   = cnt_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    bcd_n   = bcd_q;
    case (state)
      IDLE: begin
        if (bif.start) begin
          sh_n    = bif.bin_in;
          scr_n   = '0;
          cnt_n   = CW'(BIN_W);
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        {scr_n, sh_n} = {adj[BW-2:0], sh_q, 1'b0};
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_n   = {adj[BW-2:0], sh_q[BIN_W-1]};
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bif.busy    = busy_q;
  assign bif.done    = done_q;
  assign bif.bcd_out = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: timestamp/decimal model checked every cycle
// plus directed conversions with hand-computed results.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bif ();
  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bif(bif));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Model: a conversion accepted at edge k completes at edge k+BIN_W.
  int                  cyc = 0;
  int                  m_end = 0;
  int                  m_val = 0;
  bit                  m_busy = 1'b0;
  bit                  m_done = 1'b0;
  logic [4*DIGITS-1:0] m_bcd = '0;
  bit                  armed = 1'b0;

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_bcd  = '0;
      armed  = 1'b1;
    end else if (!m_busy) begin
      if (bif.start) begin
        m_busy = 1'b1;
        m_end  = cyc + BIN_W;
        m_val  = int'(bif.bin_in);
      end
    end else if (cyc == m_end) begin
      m_busy = 1'b0;
      m_done = 1'b1;
      m_bcd  = to_bcd(m_val);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(bif.busy), 32'(m_busy));
      chk("done", 32'(bif.done), 32'(m_done));
      chk("bcd_out", 32'(bif.bcd_out), 32'(m_bcd));
    end
  end

  logic [4*DIGITS-1:0] last_res = '0;

  // One conversion; optionally pulses a second start (value 17) at cycle inj_at.
  task automatic conv(input int v, input int inj_at, output logic [4*DIGITS-1:0] res);
    bit got;
    int nb;
    got = 1'b0;
    nb  = 0;
    res = '0;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = BIN_W'(v);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bif.start  = 1'b0;
        bif.bin_in = BIN_W'($urandom);
      end
      if (inj_at != 0 && n == inj_at) begin
        bif.start  = 1'b1;
        bif.bin_in = BIN_W'(17);
      end
      if (inj_at != 0 && n == inj_at + 1) bif.start = 1'b0;
      if (n == 2) chk("hold_prev", 32'(bif.bcd_out), 32'(last_res));
      if (bif.busy) nb++;
      if (bif.done) begin
        chk("latency", n, BIN_W + 1);
        chk("busy_cycles", nb, BIN_W);
        res = bif.bcd_out;
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    last_res = res;
  endtask

  initial begin
    logic [4*DIGITS-1:0] res;
    int seq [4];
    int k, last;
    seq = '{37, 128, 37, 128};
    bif.start  = 1'b0;
    bif.bin_in = '0;

    chk("model_255", 32'(to_bcd(255)), 32'h255);
    chk("model_99",  32'(to_bcd(99)),  32'h099);
    chk("model_100", 32'(to_bcd(100)), 32'h100);

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bif.busy), 0);
    chk("reset_done", 32'(bif.done), 0);
    chk("reset_bcd",  32'(bif.bcd_out), 0);
    rst = 1'b0;

    conv(0, 0, res);   chk("conv_0",   32'(res), 32'h000);
    conv(255, 0, res); chk("conv_255", 32'(res), 32'h255);
    conv(99, 0, res);  chk("conv_99",  32'(res), 32'h099);
    conv(100, 0, res); chk("conv_100", 32'(res), 32'h100);
    conv(9, 0, res);   chk("conv_9",   32'(res), 32'h009);
    conv(200, 3, res); chk("ignore_start", 32'(res), 32'h200);

    // Back-to-back with start held high
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = BIN_W'(seq[0]);
    k = 0;
    last = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bif.done) begin
        chk("b2b_value", 32'(bif.bcd_out), 32'(to_bcd(seq[k])));
        if (k > 0) chk("b2b_period", n - last, BIN_W + 1);
        last = n;
        k++;
        if (k == 4) break;
        bif.bin_in = BIN_W'(seq[k]);
      end
    end
    bif.start = 1'b0;
    chk("b2b_count", k, 4);
    chk("b2b_last_lit", 32'(bif.bcd_out), 32'h128);
    repeat (BIN_W + 3) @(negedge clk);

    // Reset in the middle of a conversion of 250
    @(negedge clk);
    bif.start  = 1'b1;
    bif.bin_in = BIN_W'(250);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bif.start = 1'b0;
      if (n == 4) rst = 1'b1;
      if (n == 5) begin
        rst = 1'b0;
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_done", 32'(bif.done), 0);
        chk("rst_bcd",  32'(bif.bcd_out), 0);
      end
      if (n > 5) chk("rst_no_done", 32'(bif.done), 0);
    end
    last_res = '0;
    conv(42, 0, res); chk("conv_42", 32'(res), 32'h042);

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      conv(v, 0, res);
      chk("sweep", 32'(res), 32'(to_bcd(v)));
      for (int d = 0; d < DIGITS; d++) begin
        int p;
        p = (d == 0) ? 1 : (d == 1) ? 10 : 100;
        chk("digit_le9", 32'(res[4*d +: 4] <= 4'd9), 1);
        chk("xs3_digit", 32'(res[4*d +: 4] + 4'd3), 32'(((v / p) % 10) + 3));
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative (shift-add-3, "double dabble") binary-to-BCD converter.
- Sits directly upstream of the BCD-to-excess-3 stage: each 4-bit digit of bcd_out feeds one excess-3 converter instance.
- Converts one BIN_W-bit unsigned value per request using a start/busy/done handshake, one bit per clock.

Parameters:
- BIN_W, 8: width of the unsigned binary input.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W-1. Behaviour is undefined if this does not hold.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  BIN_W  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse; bcd_out is valid with the new result.
- bcd_out  output  4*DIGITS  packed BCD result. Digit 0 (units) is bits [3:0]. Each digit is 0..9.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; busy=0, done=0, bcd_out=0.
  - Internal shift register and bit counter are cleared.
  - Reset overrides start and any in-progress conversion. The partial result is discarded and bcd_out is not updated.
- Internal state:
  - Binary shift register, BIN_W bits.
  - BCD scratch register, 4*DIGITS bits.
  - Bit counter, ceil(log2(BIN_W+1)) bits.
- FSM states: IDLE and SHIFT.
  - IDLE:
    - If start=1 at the edge: load the shift register with bin_in, clear scratch, set counter=BIN_W, set busy=1, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: on each edge, in this order:
    - Every scratch digit >= 5 gets +3 (4-bit add, no carry out of the digit).
    - The concatenation {scratch, shift register} shifts left by 1. The binary MSB enters scratch bit 0.
    - Counter decrements.
    - On the edge where the counter goes 1 -> 0: bcd_out <= final scratch value, done <= 1, busy <= 0, go to IDLE.
- done is high for exactly one cycle, then returns to 0 on the next edge.
- Latency:
  - start sampled at edge k; done=1 and bcd_out valid in the cycle following edge k+BIN_W.
  - busy=1 during the cycles following edges k .. k+BIN_W-1.
  - Throughput is one conversion per BIN_W+1 cycles. Back-to-back operation gives BIN_W cycles of busy plus the done cycle.
- start while busy=1 is ignored; no queueing.
- start=1 in the done cycle: the FSM is in IDLE, so the request is accepted. busy rises on that edge and done falls.
- bcd_out holds the previous result for the whole conversion and changes only on the done edge or on reset.
- bin_in is don't-care except on the accepting edge. Changes to bin_in mid-conversion have no effect.
- Combinational paths: none from inputs to outputs. All outputs are registered.

Test Plan:
- Reset, then start with bin_in=0: busy high for 8 cycles, then done pulses for 1 cycle with bcd_out=12'h000.
- bin_in=255: bcd_out=12'h255. bin_in=99: 12'h099. bin_in=100: 12'h100. bin_in=9: 12'h009. Check done timing is exactly BIN_W cycles after the start edge.
- Start with bin_in=200, then pulse start with bin_in=17 at cycle 3 of the conversion: the second start is ignored and the result is 12'h200. bcd_out keeps the previous value (e.g. 12'h009) until done.
- Hold start=1 continuously with bin_in alternating 37/128: conversions run back-to-back. done pulses every 9 cycles with 12'h037, 12'h128, and so on.
- Assert rst at cycle 4 of a conversion of 250: busy=0, done=0, bcd_out=0 the next cycle, and no done pulse follows. A new start with 42 yields 12'h042.
- Exhaustive sweep 0..255 against a reference model: every digit <= 9, result correct, and each digit fed to the excess-3 stage gives digit+3.
